// File: rtl/menu_pkg.sv
// ---------------------------------------------------------------------------
// menu_pkg
// Shared constants and types for the menu button renderer:
//   - RGB444 colour constants (BLACK, WHITE, TOUCH, CLICK, LOCK_C)
//   - 2-bit background image codes (BG_BLACK, BG_WHITE, BG_BTN, BG_EDGE)
//   - per-button state encoding (btn_state_t)
//   - background image geometry (W, PIXELS)
//   - helpers: rectangle hit test and state-to-colour map
// Optional feature macro: MENU_BTN_LOCK_EN (see menu_button_pixel_gen).
// ---------------------------------------------------------------------------
package menu_pkg;

    localparam logic [11:0] BLACK  = 12'h000;
    localparam logic [11:0] WHITE  = 12'hFFF;
    localparam logic [11:0] TOUCH  = 12'h32E;
    localparam logic [11:0] CLICK  = 12'h3E2;
    localparam logic [11:0] LOCK_C = 12'h2F5;

    localparam logic [1:0] BG_BLACK = 2'd0;
    localparam logic [1:0] BG_WHITE = 2'd1;
    localparam logic [1:0] BG_BTN   = 2'd2;
    localparam logic [1:0] BG_EDGE  = 2'd3;

    localparam int W      = 320;
    localparam int PIXELS = 76800;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOVER  = 2'd1,
        PRESS  = 2'd2,
        LOCKED = 2'd3
    } btn_state_t;

    // Left/top edges inclusive, right/bottom edges exclusive.
    function automatic logic in_rect(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [9:0] x0,
        input logic [9:0] x1,
        input logic [9:0] y0,
        input logic [9:0] y1
    );
        return (x >= x0) && (x < x1) && (y >= y0) && (y < y1);
    endfunction

    // LOCKED can only be entered when the lock feature is built in, so in the
    // default build code-2 pixels only ever show BLACK, TOUCH or CLICK.
    function automatic logic [11:0] state_colour(input btn_state_t s);
        case (s)
            HOVER:   return TOUCH;
            PRESS:   return CLICK;
            LOCKED:  return LOCK_C;
            default: return BLACK;
        endcase
    endfunction

endpackage

// File: rtl/menu_btn_fsm.sv
// ---------------------------------------------------------------------------
// menu_btn_fsm
// Hover/press/lock state machine for one menu button, one transition per
// cycle. Emits a registered one-cycle click pulse on PRESS -> HOVER.
// Ports:
//   clk, rst_n   pixel clock, asynchronous active-low reset
//   owns         cursor currently owns this button (priority already resolved)
//   mouse_left   left mouse button level
//   lock         lock request (tied low by the parent when locking is disabled)
//   state        current state (drives the button colour)
//   click        one-cycle click pulse
// Optional feature macro: MENU_BTN_LOCK_EN (gated in the parent).
// ---------------------------------------------------------------------------
module menu_btn_fsm
    import menu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       owns,
    input  logic       mouse_left,
    input  logic       lock,
    output btn_state_t state,
    output logic       click
);

    btn_state_t r_state;
    btn_state_t w_next;
    logic       r_click;
    logic       w_click;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_click <= 1'b0;
        end else begin
            r_state <= w_next;
            r_click <= w_click;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    always_comb begin
        w_next  = r_state;
        w_click = 1'b0;
        if (lock) begin
            // Lock wins over everything, including a release that would click.
            w_next = LOCKED;
        end else begin
            case (r_state)
                IDLE: begin
                    // A press that started elsewhere must be released before
                    // this button reacts.
                    if (owns && !mouse_left) w_next = HOVER;
                end
                HOVER: begin
                    if (!owns)           w_next = IDLE;
                    else if (mouse_left) w_next = PRESS;
                end
                PRESS: begin
                    if (!owns) begin
                        w_next = IDLE;      // drag-off cancels the click
                    end else if (!mouse_left) begin
                        w_next  = HOVER;
                        w_click = 1'b1;
                    end
                end
                default: w_next = IDLE;     // LOCKED with lock released
            endcase
        end
    end

    assign state = r_state;
    assign click = r_click;

endmodule

// File: rtl/menu_button_pixel_gen.sv
// ---------------------------------------------------------------------------
// menu_button_pixel_gen
// Menu renderer: NUM_BTN clickable buttons drawn over a 320x240 2-bit
// background image that is upscaled 2x to 640x480.
// Ports:
//   clk, rst_n        pixel clock, asynchronous active-low reset
//   h_cnt, v_cnt      current pixel column/row from the VGA counter
//   valid             display-active flag
//   mouse_x, mouse_y  cursor position; mouse_left: left button level
//   btn_lock          per-button lock request (honoured only with the macro)
//   mem_addr          background BRAM address (combinational)
//   mem_data          BRAM code, MEM_LAT cycles after mem_addr
//   pixel_out         registered RGB444 pixel, MEM_LAT+1 cycles after h/v
//   btn_click         one-cycle click pulse per button
//   btn_hover         registered: cursor owns button i
// Optional feature macro: MENU_BTN_LOCK_EN enables btn_lock and the LOCKED
// state; without it btn_lock is ignored.
// ---------------------------------------------------------------------------
module menu_button_pixel_gen
    import menu_pkg::*;
#(
    parameter int                    NUM_BTN = 2,
    parameter int                    MEM_LAT = 1,
    parameter logic [NUM_BTN*10-1:0] BTN_X0  = {10'd220, 10'd220},
    parameter logic [NUM_BTN*10-1:0] BTN_X1  = {10'd420, 10'd420},
    parameter logic [NUM_BTN*10-1:0] BTN_Y0  = {10'd320, 10'd200},
    parameter logic [NUM_BTN*10-1:0] BTN_Y1  = {10'd380, 10'd300}
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         h_cnt,
    input  logic [9:0]         v_cnt,
    input  logic               valid,
    input  logic [9:0]         mouse_x,
    input  logic [9:0]         mouse_y,
    input  logic               mouse_left,
    input  logic [NUM_BTN-1:0] btn_lock,
    output logic [16:0]        mem_addr,
    input  logic [1:0]         mem_data,
    output logic [11:0]        pixel_out,
    output logic [NUM_BTN-1:0] btn_click,
    output logic [NUM_BTN-1:0] btn_hover
);

    // ---------------- address generator ----------------
    logic [16:0] w_col;
    logic [16:0] w_row;
    logic [16:0] w_sum;

    assign w_col = {8'd0, h_cnt[9:1]};
    assign w_row = {8'd0, v_cnt[9:1]};
    // W = 320 = 256 + 64; the product is truncated to 17 bits exactly like
    // the shift-add form. One conditional subtract is enough for the modulo
    // because a 17-bit sum is always below 2*PIXELS.
    assign w_sum    = w_col + w_row * 17'(W);
    assign mem_addr = (w_sum >= 17'(PIXELS)) ? w_sum - 17'(PIXELS) : w_sum;

    // ---------------- delay pipes (align h/v/valid with mem_data) ----------------
    logic [9:0] r_h_pipe   [MEM_LAT];
    logic [9:0] r_v_pipe   [MEM_LAT];
    logic       r_vld_pipe [MEM_LAT];

    // NOTE: these pipes are a few flops, not RAM, so they are reset; that
    // keeps the first frame after reset black instead of showing stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                r_h_pipe[i]   <= '0;
                r_v_pipe[i]   <= '0;
                r_vld_pipe[i] <= 1'b0;
            end
        end else begin
            r_h_pipe[0]   <= h_cnt;
            r_v_pipe[0]   <= v_cnt;
            r_vld_pipe[0] <= valid;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_h_pipe[i]   <= r_h_pipe[i-1];
                r_v_pipe[i]   <= r_v_pipe[i-1];
                r_vld_pipe[i] <= r_vld_pipe[i-1];
            end
        end
    end

    logic [9:0] w_h_al;
    logic [9:0] w_v_al;
    logic       w_vld_al;

    assign w_h_al   = r_h_pipe[MEM_LAT-1];
    assign w_v_al   = r_v_pipe[MEM_LAT-1];
    assign w_vld_al = r_vld_pipe[MEM_LAT-1];

    // ---------------- lock gating ----------------
    logic [NUM_BTN-1:0] w_lock;

`ifdef MENU_BTN_LOCK_EN
    assign w_lock = btn_lock;
`else
    logic w_unused_lock;
    assign w_lock        = '0;
    assign w_unused_lock = ^btn_lock;
`endif

    // ---------------- per-button hit tests and FSMs ----------------
    logic [NUM_BTN-1:0] w_mouse_in;
    logic [NUM_BTN-1:0] w_pix_in;
    logic [NUM_BTN-1:0] w_owns;
    logic [NUM_BTN-1:0] w_click;
    btn_state_t         w_state [NUM_BTN];

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        assign w_mouse_in[g] = in_rect(mouse_x, mouse_y,
                                       BTN_X0[10*g +: 10], BTN_X1[10*g +: 10],
                                       BTN_Y0[10*g +: 10], BTN_Y1[10*g +: 10]);
        assign w_pix_in[g]   = in_rect(w_h_al, w_v_al,
                                       BTN_X0[10*g +: 10], BTN_X1[10*g +: 10],
                                       BTN_Y0[10*g +: 10], BTN_Y1[10*g +: 10]);

        menu_btn_fsm u_fsm (
            .clk        (clk),
            .rst_n      (rst_n),
            .owns       (w_owns[g]),
            .mouse_left (mouse_left),
            .lock       (w_lock[g]),
            .state      (w_state[g]),
            .click      (w_click[g])
        );
    end

    // Priority encoders: scanning from the top index down lets the lowest
    // index overwrite, so overlapping buttons resolve to the lowest index.
    logic [11:0] w_btn_colour;

    always_comb begin
        w_owns       = '0;
        w_btn_colour = BLACK;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (w_mouse_in[i]) begin
                w_owns    = '0;
                w_owns[i] = 1'b1;
            end
            if (w_pix_in[i]) w_btn_colour = state_colour(w_state[i]);
        end
    end

    // ---------------- pixel mux ----------------
    logic [11:0] w_pixel;

    always_comb begin
        w_pixel = BLACK;
        if (w_vld_al) begin
            case (mem_data)
                BG_WHITE, BG_EDGE: w_pixel = WHITE;
                BG_BTN:            w_pixel = w_btn_colour;
                default:           w_pixel = BLACK;
            endcase
        end
    end

    // ---------------- output registers ----------------
    logic [11:0]        r_pixel;
    logic [NUM_BTN-1:0] r_hover;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pixel <= BLACK;
            r_hover <= '0;
        end else begin
            r_pixel <= w_pixel;
            r_hover <= w_owns;
        end
    end

    assign pixel_out = r_pixel;
    assign btn_hover = r_hover;
    assign btn_click = w_click;     // registered inside each FSM

endmodule

// File: tb/tb_menu_button_pixel_gen.sv
// ---------------------------------------------------------------------------
// tb_menu_button_pixel_gen
// Directed vectors with hand-computed expectations. The stimulus process
// pushes each expected response, tagged with the cycle it is due, into a
// scoreboard queue; the monitor process compares entries as they fall due.
// Default geometry: button 0 = x[220,420) y[200,300),
//                   button 1 = x[220,420) y[320,380).
// ---------------------------------------------------------------------------
module tb_menu_button_pixel_gen;

    localparam int NUM_BTN = 2;
    localparam int MEM_LAT = 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [9:0]          h_cnt, v_cnt, mouse_x, mouse_y;
    logic                valid, mouse_left;
    logic [NUM_BTN-1:0]  btn_lock;
    logic [16:0]         mem_addr;
    logic [1:0]          mem_data;
    logic [11:0]         pixel_out;
    logic [NUM_BTN-1:0]  btn_click, btn_hover;

    always #5 clk = ~clk;

    menu_button_pixel_gen #(.NUM_BTN(NUM_BTN), .MEM_LAT(MEM_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .valid      (valid),
        .mouse_x    (mouse_x),
        .mouse_y    (mouse_y),
        .mouse_left (mouse_left),
        .btn_lock   (btn_lock),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .pixel_out  (pixel_out),
        .btn_click  (btn_click),
        .btn_hover  (btn_hover)
    );

    // BRAM model: the code driven with h/v is what lives at that address,
    // returned MEM_LAT cycles later.
    logic [1:0] bg_code;
    logic [1:0] bram_pipe [MEM_LAT];

    always @(posedge clk) begin
        bram_pipe[0] <= bg_code;
        for (int i = 1; i < MEM_LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
    end
    assign mem_data = bram_pipe[MEM_LAT-1];

    // ---------------- scoreboard ----------------
    typedef enum {K_ADDR, K_PIX, K_HOVER, K_CLICK} kind_e;
    typedef struct {
        int          due;
        kind_e       kind;
        logic [16:0] exp;
        string       name;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       cyc    = 0;
    int       n_test = 0;
    int       n_fail = 0;
    int       row_no = 0;

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_test++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input kind_e kind, input int lat, input logic [16:0] exp, input string tag);
        sb_item_t it;
        it.due  = cyc + lat;
        it.kind = kind;
        it.exp  = exp;
        it.name = $sformatf("r%0d_%s", row_no, tag);
        sb_q.push_back(it);
    endtask

    // Monitor: 1 ns after each rising edge, compare everything due now.
    initial begin : monitor
        logic [16:0] act;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                if (sb_q[i].due <= cyc) begin
                    case (sb_q[i].kind)
                        K_ADDR:  act = mem_addr;
                        K_PIX:   act = {5'd0, pixel_out};
                        K_HOVER: act = {15'd0, btn_hover};
                        default: act = {15'd0, btn_click};
                    endcase
                    if (sb_q[i].due < cyc)
                        check({sb_q[i].name, "_stale"}, 17'(sb_q[i].due), 17'(cyc));
                    else
                        check(sb_q[i].name, act, sb_q[i].exp);
                    sb_q.delete(i);
                end
            end
        end
    end

    // One vector = one clock cycle of inputs plus the expected responses.
    // hover/click/addr are due one edge later; the pixel MEM_LAT+1 edges later
    // and reflects button states after this vector's edge.
    task automatic run(input int h, input int v, input bit vld, input bit [1:0] code,
                       input int mx, input int my, input bit ml, input bit [1:0] lock,
                       input int addr, input bit [11:0] pix,
                       input bit [1:0] hov, input bit [1:0] clk_exp);
        @(negedge clk);
        row_no++;
        h_cnt      = 10'(h);
        v_cnt      = 10'(v);
        valid      = vld;
        bg_code    = code;
        mouse_x    = 10'(mx);
        mouse_y    = 10'(my);
        mouse_left = ml;
        btn_lock   = lock;
        push(K_ADDR,  1,           17'(addr),          "addr");
        push(K_HOVER, 1,           {15'd0, hov},       "hover");
        push(K_CLICK, 1,           {15'd0, clk_exp},   "click");
        push(K_PIX,   MEM_LAT + 1, {5'd0, pix},        "pixel");
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // ---- T1: reset behaviour ----
        rst_n = 1'b0;
        h_cnt = 10'd639; v_cnt = 10'd479; valid = 1'b1; bg_code = 2'd1;
        mouse_x = 10'd300; mouse_y = 10'd250; mouse_left = 1'b1; btn_lock = '0;
        @(negedge clk);
        push(K_ADDR,  1, 17'd76799, "rst_addr");
        push(K_PIX,   1, 17'd0,     "rst_pixel1");
        push(K_PIX,   2, 17'd0,     "rst_pixel2");
        push(K_HOVER, 1, 17'd0,     "rst_hover");
        push(K_CLICK, 1, 17'd0,     "rst_click");
        repeat (3) @(negedge clk);
        valid = 1'b0; mouse_x = '0; mouse_y = '0; mouse_left = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        //   h     v   vld code  mx   my  ml lock  addr   pixel   hov    clk
        run(5,    5,   0, 2'd1,  0,   0,  0, 2'b00,  642, 12'h000, 2'b00, 2'b00);
        run(0,    0,   1, 2'd1,  0,   0,  0, 2'b00,    0, 12'hFFF, 2'b00, 2'b00);
        run(639,  479, 1, 2'd1,  0,   0,  0, 2'b00, 76799,12'hFFF, 2'b00, 2'b00);
        run(1023, 1023,0, 2'd3,  0,   0,  0, 2'b00, 32959,12'h000, 2'b00, 2'b00);
        run(0,    480, 0, 2'd0,  0,   0,  0, 2'b00,    0, 12'h000, 2'b00, 2'b00);
        run(2,    482, 1, 2'd0,  0,   0,  0, 2'b00,  321, 12'h000, 2'b00, 2'b00);
        run(100,  100, 1, 2'd3,  0,   0,  0, 2'b00, 16050,12'hFFF, 2'b00, 2'b00);
        run(100,  100, 1, 2'd2,  0,   0,  0, 2'b00, 16050,12'h000, 2'b00, 2'b00);
        // ---- T2: hover button 0, rect edges ----
        run(300,  250, 1, 2'd2,  300, 250, 0, 2'b00, 40150,12'h32E, 2'b01, 2'b00);
        run(300,  350, 1, 2'd2,  300, 250, 0, 2'b00, 56150,12'h000, 2'b01, 2'b00);
        run(419,  299, 1, 2'd2,  300, 250, 0, 2'b00, 47889,12'h32E, 2'b01, 2'b00);
        run(420,  250, 1, 2'd2,  300, 250, 0, 2'b00, 40210,12'h000, 2'b01, 2'b00);
        run(220,  200, 1, 2'd2,  300, 250, 0, 2'b00, 32110,12'h32E, 2'b01, 2'b00);
        // ---- T3: press 5 cycles, release -> single click ----
        for (int i = 0; i < 5; i++)
            run(300, 250, 1, 2'd2, 300, 250, 1, 2'b00, 40150, 12'h3E2, 2'b01, 2'b00);
        run(300,  250, 1, 2'd2,  300, 250, 0, 2'b00, 40150,12'h32E, 2'b01, 2'b01);
        run(300,  250, 1, 2'd2,  300, 250, 0, 2'b00, 40150,12'h32E, 2'b01, 2'b00);
        // ---- T4: press, drag to button 1, release -> no click ----
        run(300,  250, 1, 2'd2,  300, 250, 1, 2'b00, 40150,12'h3E2, 2'b01, 2'b00);
        run(300,  350, 1, 2'd2,  300, 350, 1, 2'b00, 56150,12'h000, 2'b10, 2'b00);
        run(300,  250, 1, 2'd2,  300, 350, 1, 2'b00, 40150,12'h000, 2'b10, 2'b00);
        run(300,  350, 1, 2'd2,  300, 350, 0, 2'b00, 56150,12'h32E, 2'b10, 2'b00);
        run(300,  250, 1, 2'd2,  300, 350, 0, 2'b00, 40150,12'h000, 2'b10, 2'b00);
        run(300,  350, 1, 2'd2,  420, 350, 0, 2'b00, 56150,12'h000, 2'b00, 2'b00);
        run(300,  350, 1, 2'd2,  419, 379, 0, 2'b00, 56150,12'h32E, 2'b10, 2'b00);
        // ---- T6: reset while button 0 is pressed ----
        run(300,  250, 1, 2'd2,  300, 250, 0, 2'b00, 40150,12'h32E, 2'b01, 2'b00);
        run(300,  250, 1, 2'd2,  300, 250, 1, 2'b00, 40150,12'h3E2, 2'b01, 2'b00);
        run(100,  100, 1, 2'd0,  300, 250, 1, 2'b00, 16050,12'h000, 2'b01, 2'b00);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_pixel", {5'd0, pixel_out},  17'd0);
        check("async_rst_hover", {15'd0, btn_hover}, 17'd0);
        check("async_rst_click", {15'd0, btn_click}, 17'd0);
        valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(300,  250, 1, 2'd2,  300, 250, 1, 2'b00, 40150,12'h000, 2'b01, 2'b00);
        run(300,  250, 1, 2'd2,  300, 250, 0, 2'b00, 40150,12'h32E, 2'b01, 2'b00);
        run(300,  250, 1, 2'd2,  300, 250, 0, 2'b00, 40150,12'h32E, 2'b01, 2'b00);
`ifdef MENU_BTN_LOCK_EN
        // ---- T5: lock button 1 while pressed ----
        run(300,  350, 1, 2'd2,  300, 350, 0, 2'b00, 56150,12'h32E, 2'b10, 2'b00);
        run(300,  350, 1, 2'd2,  300, 350, 1, 2'b00, 56150,12'h3E2, 2'b10, 2'b00);
        run(300,  350, 1, 2'd2,  300, 350, 1, 2'b10, 56150,12'h2F5, 2'b10, 2'b00);
        run(300,  350, 1, 2'd2,  300, 350, 0, 2'b10, 56150,12'h2F5, 2'b10, 2'b00);
        run(300,  350, 1, 2'd2,  300, 350, 0, 2'b00, 56150,12'h000, 2'b10, 2'b00);
        run(300,  350, 1, 2'd2,  300, 350, 0, 2'b00, 56150,12'h32E, 2'b10, 2'b00);
        run(300,  350, 1, 2'd2,  300, 350, 1, 2'b00, 56150,12'h3E2, 2'b10, 2'b00);
        run(300,  350, 1, 2'd2,  300, 350, 0, 2'b10, 56150,12'h2F5, 2'b10, 2'b00);
        run(300,  350, 1, 2'd2,  300, 350, 0, 2'b00, 56150,12'h000, 2'b10, 2'b00);
`endif
        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            n_test++;
            n_fail++;
            $display("FAIL drain: got %0d pending entries, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule
